multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic ops, plus SLL/SRL that take one cycle
// per bit of shift. Handshake is start/busy/done, with registered result and flags.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDU = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SUBU = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d, done_q, done_d;

    logic [WIDTH-1:0] sum, diff, exec_res, sh_next;
    logic             exec_ovf, exec_ill;

    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;
    assign sh_next = (op_q == OP_SLL) ? (sh_q << 1) : (sh_q >> 1);

    // Single-cycle datapath, evaluated on the latched operands while in EXEC.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        exec_res = '0;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (op_q)
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_NOR:  exec_res = ~(a_q | b_q);
            OP_ADDU: exec_res = sum;
            OP_SUBU: exec_res = diff;
            OP_ADD: begin
                exec_res = sum;
                exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res = diff;
                exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_SLL, OP_SRL: exec_res = b_q;   // only reached with shamt == 0
            default: exec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                op_d  = ALUCtl;
                a_d   = a;
                b_d   = b;
                sh_d  = b;
                cnt_d = shamt;
                state_d = ((ALUCtl == OP_SLL || ALUCtl == OP_SRL) && shamt != 5'd0) ? SHIFT : EXEC;
            end
            EXEC: begin
                result_d = exec_res;
                zero_d   = (exec_res == '0);
                ovf_d    = exec_ovf;
                ill_d    = exec_ill;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = sh_next;
                    zero_d   = (sh_next == '0);
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand latches are reset along with the control state, so a restart after reset is fully deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here, so every flop samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;

endmodule
